// File: rtl/as_cgu_multi.sv
// as_cgu_multi: programmable multi-channel clock-enable generator.
//
// Every channel divides the board clock by a runtime-writable divisor and
// produces a one-cycle strobe (ce_o), a roughly 50 % duty level (clk_o) and a
// running flag (run_o). A new divisor written to DIV[c] is picked up only at the
// channel's period boundary, so a period is never shortened or stretched mid-way.
// SYNC restarts selected enabled channels together so that they run in phase.
//
// Register map (addr_i):
//   0x0..NR_CH-1  DIV[c]  shadow divisor, bits DIV_WIDTH-1:0
//   0xD           STATUS  running mask (read-only)
//   0xE           SYNC    restart mask (write-only, reads 0)
//   0xF           EN      enable mask
//   others        writes ignored, reads 0
//
// Ports:
//   clk_i    board clock
//   rst_ni   asynchronous active-low reset
//   cs_i     register access select
//   we_i     1 = write, 0 = read (qualified by cs_i)
//   addr_i   register address
//   wdata_i  write data
//   rdata_o  registered read data (valid the cycle after a read, held)
//   ce_o     per-channel strobe, high in the last cycle of each period
//   clk_o    per-channel divided level
//   run_o    per-channel running flag
module as_cgu_multi #(
  parameter int unsigned                NR_CH     = 4,
  parameter int unsigned                DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0]       RST_DIV   = DIV_WIDTH'(80),
  parameter logic [NR_CH-1:0]           RST_EN    = '1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cs_i,
  input  logic              we_i,
  input  logic [3:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [NR_CH-1:0]  ce_o,
  output logic [NR_CH-1:0]  clk_o,
  output logic [NR_CH-1:0]  run_o
);

  typedef logic [DIV_WIDTH-1:0] div_t;

  localparam div_t ONE = div_t'(1);

  div_t             div_q [NR_CH];
  div_t             act_q [NR_CH];
  div_t             act_d [NR_CH];
  div_t             cnt_q [NR_CH];
  div_t             cnt_d [NR_CH];
  logic [NR_CH-1:0] en_q, en_d;
  logic [NR_CH-1:0] run_q, run_d;
  logic [NR_CH-1:0] sync_m;
  logic [NR_CH-1:0] ce_d, clk_d;
  logic [31:0]      rdata_d;
  logic             init_q;
  logic             wr, rd;
  logic             unused_wdata;

  assign wr = cs_i & we_i;
  assign rd = cs_i & ~we_i;

  // Upper write-data bits beyond the divisor/mask fields carry no meaning.
  assign unused_wdata = ^wdata_i;

  // init_q marks the first cycle after reset release, which starts every
  // enabled channel exactly like an EN 0->1 edge so cycle 0 has cnt = 0.
  always_comb begin
    en_d   = en_q;
    sync_m = '0;
    if (wr && addr_i == 4'hF) en_d   = wdata_i[NR_CH-1:0];
    if (wr && addr_i == 4'hE) sync_m = wdata_i[NR_CH-1:0];
    for (int unsigned c = 0; c < NR_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      act_d[c] = act_q[c];
      run_d[c] = run_q[c];
      if (!en_d[c]) begin
        cnt_d[c] = '0;
        run_d[c] = 1'b0;
      end else if (init_q || !en_q[c] || sync_m[c]) begin
        cnt_d[c] = '0;
        act_d[c] = div_q[c];
        run_d[c] = (div_q[c] != '0);
      end else if (run_q[c]) begin
        // Boundary reload uses the shadow value as it stood before this
        // cycle's write, so a write in the wrap cycle waits one more period.
        if (cnt_q[c] == act_q[c] - ONE) begin
          cnt_d[c] = '0;
          act_d[c] = div_q[c];
          run_d[c] = (div_q[c] != '0);
        end else begin
          cnt_d[c] = cnt_q[c] + ONE;
        end
      end
      // Outputs are decoded from next state and registered, so ce_o/clk_o
      // leave the block straight from flops.
      ce_d[c]  = run_d[c] && (cnt_d[c] == act_d[c] - ONE);
      clk_d[c] = run_d[c] && (cnt_d[c] >= act_d[c] - (act_d[c] >> 1));
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int unsigned c = 0; c < NR_CH; c++) begin
      if (addr_i == 4'(c)) rdata_d = 32'(div_q[c]);
    end
    if (addr_i == 4'hD) rdata_d = 32'(run_q);
    if (addr_i == 4'hF) rdata_d = 32'(en_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NR_CH; c++) begin
        div_q[c] <= RST_DIV;
        act_q[c] <= RST_DIV;
        cnt_q[c] <= '0;
      end
      en_q    <= RST_EN;
      run_q   <= '0;
      init_q  <= 1'b1;
      ce_o    <= '0;
      clk_o   <= '0;
      rdata_o <= '0;
    end else begin
      for (int unsigned c = 0; c < NR_CH; c++) begin
        if (wr && addr_i == 4'(c)) div_q[c] <= wdata_i[DIV_WIDTH-1:0];
        act_q[c] <= act_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      en_q   <= en_d;
      run_q  <= run_d;
      init_q <= 1'b0;
      ce_o   <= ce_d;
      clk_o  <= clk_d;
      if (rd) rdata_o <= rdata_d;
    end
  end

  assign run_o = run_q;

endmodule

// File: doc/as_cgu_multi.md
# as_cgu_multi

Programmable multi-channel clock-enable generator, successor to the fixed-divisor CGU (core/QSPI/bus1/bus2 dividers). It sits behind the peripheral bus chip-select. From the single board clock it produces NR_CH independent divided outputs (`ce_o` strobe plus ~50 % `clk_o` level), with runtime-writable divisors. Divisor changes take effect glitch-free at period boundaries, and selected channels can be phase-synchronised.

## Interface
- NR_CH, 4: number of divider channels (1..13).
- DIV_WIDTH, 16: divisor/counter width (2..32).
- RST_DIV, 80: reset divisor of every channel.
- RST_EN, all ones (NR_CH bits): reset enable mask.
- `clk_i`  in  1  board clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `cs_i`  in  1  register access select.
- `we_i`  in  1  1 = write, 0 = read (qualified by `cs_i`).
- `addr_i`  in  4  register address.
- `wdata_i`  in  32  write data.
- `rdata_o`  out  32  read data, registered.
- `ce_o`  out  NR_CH  per-channel one-cycle enable strobe.
- `clk_o`  out  NR_CH  per-channel divided level.
- `run_o`  out  NR_CH  per-channel running flag.

## Operation
- Register map:
  - 0x0..NR_CH-1: DIV[c], shadow divisor in bits DIV_WIDTH-1:0, upper bits ignored.
  - 0xD: STATUS, read-only; running mask.
  - 0xE: SYNC, write-only; reads 0.
  - 0xF: EN, enable mask.
  - Unmapped addresses: writes ignored, reads 0.
- Per channel state: `cnt`, `div_act` (active divisor), `run`.
- `run` = EN[c] && `div_act` != 0.
- While run, each cycle: if `cnt` == `div_act`-1, then `cnt` <= 0 and `div_act` <= DIV[c]; otherwise `cnt` <= `cnt`+1.
- `ce_o[c]` = run && `cnt` == `div_act`-1.
- `clk_o[c]` = run && `cnt` >= `div_act` - (`div_act`>>1).
- Examples: div 4 gives `clk_o` high on `cnt` 2,3; div 5 gives high on `cnt` 3,4; div 1 gives `ce_o` constantly 1 and `clk_o` 0.
- `ce_o`, `clk_o` and `run_o` must be flop outputs: compute them from next-state values, with no combinational decode on the outputs.
- EN 0->1 on a channel:
  - next cycle `cnt` = 0, `div_act` = DIV[c].
  - If DIV[c] = 0, the channel stays halted.
- EN 1->0: next cycle `cnt` = 0, all outputs 0.
- Divisor 0 reached at a boundary: the channel halts with outputs 0 and `run_o` = 0. It restarts only when a nonzero divisor is written *and* EN is toggled or SYNC is written.
- SYNC write with mask m: every enabled channel in m reloads `div_act` = DIV[c] and `cnt` = 0 in the next cycle, so they start in phase. Disabled channels in m are unaffected.

## Timing
- Reset (async assert, sync-safe release):
  - DIV = RST_DIV, EN = RST_EN, `cnt` = 0, `div_act` = RST_DIV.
  - `ce_o`, `clk_o`, `run_o` and `rdata_o` are 0.
  - `run_o` becomes 1 in the first cycle after release (cycle 0).
- Cycle 0 after release has `cnt` = 0, so the first `ce_o` falls in cycle `div_act`-1.
- Register writes update at the end of the `cs_i`&&`we_i` cycle.
- EN and SYNC writes act on the counters in the following cycle.
- A DIV write never alters the current period. It is picked up at the next `cnt` wrap, even if written in the wrap cycle itself (the old value is used for the wrap being taken).
- Read latency 1: `rdata_o` is valid in the cycle after `cs_i`&&!`we_i` and holds until the next read.
- A DIV read returns the shadow value, not `div_act`.
- Reset mid-period aborts all channels immediately and restores the reset state; no partial `ce_o` pulse.

## Test plan
- Reset with RST_DIV = 4, RST_EN = 1111 -> `ce_o[0]` high in cycles 3, 7, 11; `clk_o[0]` high in cycles 2-3, 6-7; `run_o` = 1111 from cycle 0.
- Ch0 at div 4: write DIV0 = 6 when `cnt` = 1 -> next pulse still at `cnt` 3 of the current period, then every 6 cycles; DIV0 read returns 6 after 1 cycle.
- Write DIV1 = 0 -> after the current period, ch1 outputs 0 and `run_o[1]` = 0. Then write DIV1 = 3 and EN bit1 0->1 -> strobes every 3 cycles.
- Ch0 and ch1 at div 4 with offset phase; write SYNC = 0x3 -> both `cnt` = 0 next cycle and `ce_o[1:0]` = 11 together thereafter. SYNC targeting a disabled channel -> no change.
- Div 1 and div 5 -> `ce_o` continuously 1 with `clk_o` 0; div 5 gives `clk_o` high 2 of 5 cycles.
- Assert `rst_ni` mid-period -> outputs 0 asynchronously; registers return to defaults; reads of 0xE and unmapped addresses return 0.
